// File: rtl/systolic_feed_ctrl.sv
// systolic_feed_ctrl: preload, skewed-stream and drain sequencer for one lane FIFO bank feeding a DIM x DIM systolic array
module systolic_feed_ctrl #(
  parameter int DIM   = 8,
  parameter int CNT_W = $clog2(2*DIM)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic             stall,
  input  logic             abort,
  output logic             fifo_wr,
  output logic             fifo_en,
  output logic             array_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] phase_cnt,
  output logic [15:0]      tile_cnt
);
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
  localparam logic [CNT_W-1:0] S_LAST = CNT_W'(2*DIM-2);
  localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DIM-1);
  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [15:0]      tile_q;
  logic             done_q, done_d, tile_inc, go;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
      tile_q <= '0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      done_q <= done_d;
      if (tile_inc) tile_q <= tile_q + 16'd1;
    end
  end
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    done_d   = 1'b0;
    tile_inc = 1'b0;
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state == IDLE) begin
      if (ld_valid) begin
        state_d = STREAM;
        cnt_d   = '0;
      end
    end else if (!stall) begin
      if (state == STREAM && cnt == S_LAST) begin
        state_d = DRAIN;
        cnt_d   = '0;
      end else if (state == DRAIN && cnt == D_LAST) begin
        state_d  = IDLE;
        cnt_d    = '0;
        done_d   = 1'b1;
        tile_inc = 1'b1;
      end else cnt_d = cnt + CNT_W'(1);
    end
  end
  // combinational outputs are gated by rst_n so they read 0 before the reset edge lands
  assign go        = rst_n & ~abort;
  assign ld_ready  = go & (state == IDLE);
  assign fifo_wr   = ld_ready & ld_valid;
  assign fifo_en   = go & ~stall & (state == STREAM);
  assign array_en  = go & ~stall & (state != IDLE);
  assign busy      = rst_n & (state != IDLE);
  assign done      = rst_n & done_q;
  assign phase_cnt = rst_n ? cnt : '0;
  assign tile_cnt  = rst_n ? tile_q : '0;
endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// tb_systolic_feed_ctrl: directed checks of tile sequencing, stall, abort, reset and tile counter wrap at DIM=8
module tb_systolic_feed_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, ld_valid = 1'b0, stall = 1'b0, abort = 1'b0;
  logic        ld_ready, fifo_wr, fifo_en, array_en, busy, done;
  logic [3:0]  phase_cnt;
  logic [15:0] tile_cnt;
  int n_run = 0, n_fail = 0;

  systolic_feed_ctrl #(.DIM(8)) dut (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .stall(stall), .abort(abort), .fifo_wr(fifo_wr), .fifo_en(fifo_en),
    .array_en(array_en), .busy(busy), .done(done), .phase_cnt(phase_cnt),
    .tile_cnt(tile_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int c, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, c, got, exp);
    end
  endtask

  task automatic chk_all(input int c, input logic lr, input logic wr, input logic en, input logic ae,
                         input logic bz, input logic dn, input logic [3:0] ph, input logic [15:0] tc);
    chk("ld_ready", c, 32'(ld_ready), 32'(lr));
    chk("fifo_wr", c, 32'(fifo_wr), 32'(wr));
    chk("fifo_en", c, 32'(fifo_en), 32'(en));
    chk("array_en", c, 32'(array_en), 32'(ae));
    chk("busy", c, 32'(busy), 32'(bz));
    chk("done", c, 32'(done), 32'(dn));
    chk("phase_cnt", c, 32'(phase_cnt), 32'(ph));
    chk("tile_cnt", c, 32'(tile_cnt), 32'(tc));
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // one tile from IDLE; stall held in cycles s_lo..s_hi; e is the stall-free equivalent cycle
  task automatic run_tile(input int s_lo, input int s_hi, input logic [15:0] tile_exp);
    int ns, last, e;
    logic st;
    logic [3:0] ph;
    ns = 0;
    last = 25 + ((s_hi >= s_lo) ? (s_hi - s_lo + 1) : 0);
    for (int c = 0; c <= last; c++) begin
      ld_valid = (c == 0);
      st = (c >= s_lo) && (c <= s_hi);
      stall = st;
      e = c - ns;
      ph = (e >= 1 && e <= 15) ? 4'(e - 1) : (e >= 16 && e <= 23) ? 4'(e - 16) : 4'd0;
      @(negedge clk);
      chk_all(c, e == 0 || e >= 24, c == 0, !st && e >= 1 && e <= 15, !st && e >= 1 && e <= 23,
              e >= 1 && e <= 23, e == 24, ph, (e >= 24) ? tile_exp : tile_exp - 16'd1);
      nxt();
      if (st) ns++;
    end
    ld_valid = 1'b0;
    stall = 1'b0;
  endtask

  initial begin
    ld_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk_all(-1, 0, 0, 0, 0, 0, 0, 4'd0, 16'd0);
    nxt();
    rst_n = 1'b1;
    ld_valid = 1'b0;
    @(negedge clk);
    chk_all(-1, 1, 0, 0, 0, 0, 0, 4'd0, 16'd0);
    nxt();

    run_tile(-1, -2, 16'd1);
    run_tile(5, 7, 16'd2);

    ld_valid = 1'b1;
    for (int c = 0; c <= 48; c++) begin
      int e;
      e = c % 24;
      @(negedge clk);
      chk_all(c, e == 0, e == 0, e >= 1 && e <= 15, e >= 1, e >= 1, c == 24 || c == 48,
              (e >= 1 && e <= 15) ? 4'(e - 1) : (e >= 16) ? 4'(e - 16) : 4'd0,
              (c < 24) ? 16'd2 : (c < 48) ? 16'd3 : 16'd4);
      nxt();
    end
    ld_valid = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    chk_all(49, 0, 0, 0, 0, 1, 0, 4'd0, 16'd4);
    nxt();
    abort = 1'b0;
    @(negedge clk);
    chk_all(50, 1, 0, 0, 0, 0, 0, 4'd0, 16'd4);
    nxt();

    ld_valid = 1'b1;
    nxt();
    ld_valid = 1'b0;
    repeat (19) nxt();
    abort = 1'b1;
    stall = 1'b1;
    @(negedge clk);
    chk_all(20, 0, 0, 0, 0, 1, 0, 4'd4, 16'd4);
    nxt();
    abort = 1'b0;
    stall = 1'b0;
    for (int c = 21; c <= 26; c++) begin
      @(negedge clk);
      chk_all(c, 1, 0, 0, 0, 0, 0, 4'd0, 16'd4);
      nxt();
    end
    run_tile(-1, -2, 16'd5);

    ld_valid = 1'b1;
    nxt();
    ld_valid = 1'b0;
    repeat (5) nxt();
    rst_n = 1'b0;
    ld_valid = 1'b1;
    for (int c = 6; c <= 9; c++) begin
      @(negedge clk);
      chk_all(c, 0, 0, 0, 0, 0, 0, 4'd0, 16'd0);
      nxt();
    end
    rst_n = 1'b1;
    ld_valid = 1'b0;
    run_tile(-1, -2, 16'd1);

    force dut.tile_q = 16'hFFFF;
    @(negedge clk);
    chk("tile_preset", 0, 32'(tile_cnt), 32'h0000FFFF);
    nxt();
    release dut.tile_q;
    run_tile(-1, -2, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/systolic_feed_ctrl.md
Name: systolic_feed_ctrl

Overview:
- Sequences one bank of DIM skewed preload lane FIFOs that feed a DIM x DIM systolic array.
- On each tile handshake it pulses a shared preload write to all lanes, then shifts them for 2*DIM-1 cycles.
- It then keeps the array enabled for DIM drain cycles and signals completion.
- It sits between the tile source (load handshake) and the lane FIFO bank plus array enable, and it honours array stalls and software abort.

Parameters:
- DIM, 8: lanes per bank and FIFO depth. Legal range 2..64.
- CNT_W, $clog2(2*DIM): phase counter width. Derived; do not override.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ld_valid  in  1  tile source has DIM-wide lane data on the FIFO d buses.
- ld_ready  out  1  controller accepts a tile this cycle.
- stall  in  1  array back-pressure; freezes shifting and counting.
- abort  in  1  synchronous cancel of the current tile.
- fifo_wr  out  1  shared preload strobe to all lane FIFOs.
- fifo_en  out  1  shared shift enable to all lane FIFOs.
- array_en  out  1  systolic array compute enable.
- busy  out  1  tile in flight.
- done  out  1  one-cycle tile-complete pulse.
- phase_cnt  out  CNT_W  current STREAM/DRAIN counter value.
- tile_cnt  out  16  completed tiles, wraps at 2^16.

Behaviour:
- Reset: clk and rst_n as already decided; reset is sampled only on a rising clk edge.
  - While rst_n is low, all outputs are forced to 0, including the combinational ld_ready and fifo_wr.
  - State returns to IDLE; phase_cnt and tile_cnt are cleared.
  - Reset mid-tile discards the tile; no done pulse is produced.
- IDLE:
  - ld_ready = ~abort.
  - fifo_wr = ld_valid & ld_ready, combinational, so lane data is captured on the handshake edge.
  - The handshake moves the state to STREAM with phase_cnt=0.
  - stall has no effect on acceptance.
- STREAM:
  - fifo_en = array_en = ~stall.
  - phase_cnt increments on each non-stalled cycle.
  - When phase_cnt==2*DIM-2 on a non-stalled cycle, go to DRAIN with phase_cnt=0.
- DRAIN:
  - fifo_en=0; array_en = ~stall.
  - phase_cnt increments on each non-stalled cycle.
  - When phase_cnt==DIM-1 on a non-stalled cycle, go to IDLE, register done=1 for the next cycle only, and increment tile_cnt.
- Outputs in non-IDLE states: ld_ready=0 and fifo_wr=0. A preload must never overlap shifting, because the lane FIFOs give write priority over shift.
- busy = (state != IDLE).
- Stall-free tile latency: handshake at cycle 0; fifo_en high in cycles 1..2*DIM-1; array_en high in cycles 1..3*DIM-1; done in cycle 3*DIM.
  - done coincides with IDLE and ld_ready=1, so a back-to-back handshake in the done cycle is legal. It gives zero bubble between tiles' IDLE periods.
- Stall: outputs fifo_en and array_en drop in the same cycle (combinational). State and counters hold. There is no limit on stall length.
- Abort (priority below reset, above everything else):
  - Next cycle: state=IDLE, phase_cnt=0, no done, tile_cnt unchanged.
  - In the abort cycle itself, ld_ready, fifo_wr, fifo_en and array_en are forced to 0.
  - Lane FIFO contents are left stale; the next preload overwrites every entry.
- Simultaneous stall+abort: abort wins.
- Simultaneous final drain advance+abort: abort wins, so there is no done and no tile_cnt increment.
- ld_valid outside IDLE is ignored. The source holds it until ld_ready.

Test Plan:
- Reset, then a single tile (DIM=8, no stall). ld_valid=1 at cycle 0:
  - fifo_wr=1 in cycle 0 only.
  - fifo_en high in cycles 1..15; array_en high in cycles 1..23.
  - done=1 in cycle 24; tile_cnt=1; busy high in cycles 1..23.
- Stall injection: stall=1 in cycles 5..7 of STREAM.
  - fifo_en and array_en are 0 in those cycles and phase_cnt holds.
  - done moves to cycle 27.
- Back-to-back tiles: ld_valid held high.
  - Second handshake occurs in cycle 24 (done and fifo_wr both high).
  - Second done in cycle 48; tile_cnt=2.
- Abort during DRAIN at cycle 20 (with stall also asserted):
  - Cycle 21 is IDLE with busy=0.
  - No done; tile_cnt unchanged; the next tile completes normally.
- Reset mid-STREAM: rst_n=0 at cycle 6.
  - All outputs are 0 from cycle 6 on; ld_ready stays 0 while rst_n is low.
  - After release, the next tile behaves as in the first scenario.
- tile_cnt wrap: preset to 16'hFFFF via 65535 tiles, or force the counter in the bench; one more tile reads 0.
